// File: rtl/drive_pkg.sv
// drive_pkg: shared state encoding, driving-mode constants and default widths for drive_mode_ctrl
package drive_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, SELECT = 2'd1, RUN = 2'd2} state_t;
  localparam int MODE_MANUAL = 0;
  localparam int MODE_SEMI = 1;
  localparam int MODE_AUTO = 2;
  localparam int DEF_MODE_W = 2;
  localparam int DEF_NUM_MODES = MODE_AUTO + 1;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser followed by a consecutive-cycle debounce filter
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  localparam int cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [cnt_w-1:0] cnt;
  logic done;
  assign done = cnt == cnt_w'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      sync <= {sync[0], in};
      cnt <= (sync[1] == out || done) ? '0 : cnt + 1'b1;
      out <= (sync[1] != out && done) ? sync[1] : out;
    end
endmodule

// File: rtl/drive_mode_ctrl.sv
// drive_mode_ctrl: long-press power sequencing and driving-mode selection; AUTO_OFF_EN adds idle power-off
module drive_mode_ctrl
  import drive_pkg::*;
#(
  parameter int MODE_W = DEF_MODE_W,
  parameter int NUM_MODES = DEF_NUM_MODES,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES = 100,
  parameter int IDLE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic [MODE_W-1:0] model_select,
  input  logic              confirm,
  input  logic              moving,
  input  logic              activity,
  output logic              power_state,
  output logic [MODE_W-1:0] model,
  output logic              model_valid
);
  localparam int hold_w = $clog2(HOLD_CYCLES + 1);
  state_t state, state_nxt;
  logic [MODE_W-1:0] model_nxt;
  logic [hold_w-1:0] hold_cnt;
  logic pwr_db, armed, hold_full, long_press, consume, legal, idle_to;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst(rst),
    .in(power),
    .out(pwr_db)
  );
  assign hold_full = hold_cnt == hold_w'(HOLD_CYCLES);
  assign long_press = pwr_db && armed && hold_full;
  assign consume = long_press && !(state == RUN && moving);
  assign legal = confirm && 32'(model_select) < NUM_MODES;
  assign power_state = state != OFF;
  assign model_valid = state == RUN;
`ifdef AUTO_OFF_EN
  localparam int idle_w = $clog2(IDLE_CYCLES + 1);
  logic [idle_w-1:0] idle_cnt;
  always_ff @(posedge clk)
    idle_cnt <= (rst || activity || confirm || pwr_db || moving || state == OFF) ? '0 : idle_cnt + 1'b1;
  assign idle_to = state != OFF && idle_cnt == idle_w'(IDLE_CYCLES);
`else
  logic unused_idle;
  assign unused_idle = activity ^ (IDLE_CYCLES < 0);
  assign idle_to = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= OFF;
      model <= '0;
      hold_cnt <= '0;
      armed <= 1'b1;
    end else begin
      state <= state_nxt;
      model <= model_nxt;
      hold_cnt <= pwr_db ? hold_cnt + hold_w'(!hold_full) : '0;
      armed <= !pwr_db ? 1'b1 : consume ? 1'b0 : armed;
    end
  always_comb begin
    state_nxt = state;
    model_nxt = model;
    unique case (state)
      OFF: state_nxt = long_press ? SELECT : OFF;
      SELECT:
        if (long_press || idle_to) begin
          state_nxt = OFF;
          model_nxt = MODE_W'(MODE_MANUAL);
        end else if (legal) begin
          state_nxt = RUN;
          model_nxt = model_select;
        end
      RUN:
        if ((long_press && !moving) || idle_to) begin
          state_nxt = OFF;
          model_nxt = MODE_W'(MODE_MANUAL);
        end else if (legal && !moving) begin
          model_nxt = model_select;
        end
      default: state_nxt = OFF;
    endcase
  end
endmodule

// File: tb/tb_drive_mode_ctrl.sv
// tb_drive_mode_ctrl: directed and randomized checks of drive_mode_ctrl against a behavioural model
module tb_drive_mode_ctrl;
  import drive_pkg::*;
  localparam int DB = 4;
  localparam int HOLD = 10;
  localparam int NM = 3;
  localparam int IDLE = 50;
  logic clk = 0;
  logic rst = 1;
  logic power = 0;
  logic confirm = 0;
  logic moving = 0;
  logic activity = 0;
  logic [1:0] model_select = 0;
  logic power_state, model_valid;
  logic [1:0] model;
  int tests = 0;
  int fails = 0;
  int on_at;
  bit q[$];
  bit hist[$];
  bit m_db, m_fired, m_pwr, m_run;
  int m_press, m_mode, m_idle;
  drive_mode_ctrl #(
    .MODE_W(2),
    .NUM_MODES(NM),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .power(power),
    .model_select(model_select),
    .confirm(confirm),
    .moving(moving),
    .activity(activity),
    .power_state(power_state),
    .model(model),
    .model_valid(model_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    bit s, lp, to, diff;
    if (rst) begin
      q.delete();
      q.push_back(1'b0);
      q.push_back(1'b0);
      hist.delete();
      m_db = 0; m_fired = 0; m_pwr = 0; m_run = 0;
      m_press = 0; m_mode = 0; m_idle = 0;
      return;
    end
    s = q.pop_front();
    q.push_back(power);
    lp = m_db && m_press == HOLD && !m_fired;
    to = 0;
`ifdef AUTO_OFF_EN
    to = m_pwr && m_idle == IDLE;
    m_idle = (activity || confirm || m_db || moving || !m_pwr) ? 0 : m_idle + 1;
`endif
    if (!m_pwr) begin
      if (lp) begin
        m_pwr = 1;
        m_fired = 1;
      end
    end else if ((lp && !(m_run && moving)) || to) begin
      m_pwr = 0; m_run = 0; m_mode = 0;
      m_fired = m_fired | lp;
    end else if (confirm && model_select < NM && !(m_run && moving)) begin
      m_mode = model_select;
      m_run = 1;
    end
    if (!m_db) m_fired = 0;
    m_press = m_db ? (m_press < HOLD ? m_press + 1 : HOLD) : 0;
    hist.push_back(s);
    if (hist.size() > DB) void'(hist.pop_front());
    diff = hist.size() == DB;
    foreach (hist[i]) if (hist[i] == m_db) diff = 0;
    if (diff) m_db = !m_db;
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".pwr"}, power_state, m_pwr);
    chk({tag, ".model"}, model, m_mode);
    chk({tag, ".valid"}, model_valid, m_run);
  endtask
  initial begin
    q.push_back(1'b0);
    q.push_back(1'b0);
    repeat (3) tick("reset");
    chk("reset_pwr", power_state, 0);
    chk("reset_model", model, 0);
    chk("reset_valid", model_valid, 0);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      power = i[1];
      tick("bounce");
    end
    power = 0;
    repeat (10) tick("bounce_low");
    chk("bounce_off", power_state, 0);
    power = 1;
    on_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("press");
      if (power_state === 1'b1 && on_at == 0) on_at = i;
    end
    chk("press_latency", on_at, 17);
    power = 0;
    repeat (10) tick("release");
    power = 1;
    repeat (5) tick("short");
    power = 0;
    repeat (10) tick("short_rel");
    chk("short_press_ignored", power_state, 1);
    model_select = 3; confirm = 1;
    tick("sel3");
    confirm = 0;
    chk("sel3_valid", model_valid, 0);
    chk("sel3_pwr", power_state, 1);
    model_select = 2; confirm = 1;
    tick("sel2");
    confirm = 0;
    chk("sel2_model", model, MODE_AUTO);
    chk("sel2_valid", model_valid, 1);
    moving = 1; model_select = 0; confirm = 1;
    tick("mov_conf");
    confirm = 0;
    chk("mov_conf_drop", model, MODE_AUTO);
    power = 1;
    repeat (20) tick("cancel_hold");
    power = 0;
    repeat (10) tick("cancel_rel");
    moving = 0;
    tick("cancel_stop");
    chk("cancel_pwr", power_state, 1);
    moving = 1; power = 1;
    repeat (20) tick("mov_hold");
    chk("mov_defer", power_state, 1);
    moving = 0;
    tick("mov_drop");
    chk("defer_off_pwr", power_state, 0);
    chk("defer_off_model", model, 0);
    power = 0;
    repeat (10) tick("rel2");
    power = 1;
    repeat (17) tick("on2");
    power = 0;
    repeat (10) tick("rel3");
    model_select = 2; confirm = 1;
    tick("run2");
    confirm = 0;
    power = 1;
    repeat (16) tick("coll_hold");
    model_select = 2'(MODE_SEMI); confirm = 1;
    tick("collide");
    confirm = 0;
    chk("collide_pwr", power_state, 0);
    chk("collide_model", model, 0);
    power = 0;
    repeat (10) tick("rel4");
    power = 1;
    repeat (13) tick("pre_rst");
    rst = 1;
    repeat (2) tick("mid_rst");
    rst = 0;
    on_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("post_rst");
      if (power_state === 1'b1 && on_at == 0) on_at = i;
    end
    chk("rst_restart_latency", on_at, 17);
    power = 0;
    repeat (10) tick("rel5");
    model_select = 0; confirm = 1;
    tick("run3");
    confirm = 0;
`ifdef AUTO_OFF_EN
    repeat (48) tick("idle_a");
    activity = 1;
    tick("idle_act");
    activity = 0;
    repeat (50) tick("idle_b");
    chk("idle_restart", power_state, 1);
    tick("idle_off");
    chk("idle_off", power_state, 0);
`else
    repeat (200) tick("no_idle");
    chk("no_auto_off", power_state, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) power = ~power;
      if ($urandom_range(0, 29) == 0) moving = ~moving;
      confirm = $urandom_range(0, 9) == 0;
      model_select = 2'($urandom_range(0, 3));
      activity = $urandom_range(0, 79) == 0;
      rst = $urandom_range(0, 599) == 0;
      tick("random");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
